// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: glitch-filtered device-to-host frames assembled into 3-byte packets.
// Optional PS2_PARITY_CHK_EN makes odd-parity failures frame errors; otherwise parity is ignored.
module ps2_mouse_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        rd_vld,
  output logic [23:0] rd_data,
  output logic        frame_err
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d, filt_prev_q, strobe_q;
  logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q, b0_q, b1_q;
  logic            par_q;
  logic [1:0]      idx_q;
  logic [WD_W-1:0] wd_q;
  logic            rd_vld_q, frame_err_q;
  logic [23:0]     rd_data_q;
  logic            timeout, stop_seen, frame_ok, sync_bad, accept, pkt_done, err_d;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Level only moves after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FC_LAST) begin
      filt_d     = ~filt_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FC_ONE;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      filt_prev_q <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_prev_q <= filt_q;
      strobe_q    <= filt_prev_q & ~filt_q;
    end
  end

  assign timeout = (wd_q == WD_LAST) && !strobe_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (strobe_q) begin
      case (state_q)
        S_IDLE:   if (!dat_s2_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        default:  state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    stop_seen = strobe_q && (state_q == S_STOP);
    frame_ok  = dat_s2_q && (!PAR_CHK || (^{shift_q, par_q}));
    sync_bad  = stop_seen && frame_ok && (idx_q == 2'd0) && !shift_q[3];
    accept    = stop_seen && frame_ok && !sync_bad;
    pkt_done  = accept && (idx_q == 2'd2);
    err_d     = (stop_seen && !frame_ok) || sync_bad || timeout;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      idx_q       <= 2'd0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      wd_q        <= '0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= 24'h0;
      frame_err_q <= 1'b0;
    end else begin
      if (strobe_q && state_q == S_IDLE) bit_cnt_q <= 3'd0;
      if (strobe_q && state_q == S_DATA) begin
        shift_q   <= {dat_s2_q, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (strobe_q && state_q == S_PARITY) par_q <= dat_s2_q;
      if (pkt_done || err_d)  idx_q <= 2'd0;
      else if (accept)        idx_q <= idx_q + 2'd1;
      if (accept && idx_q == 2'd0) b0_q <= shift_q;
      if (accept && idx_q == 2'd1) b1_q <= shift_q;
      if (pkt_done) rd_data_q <= {shift_q, b1_q, b0_q};
      rd_vld_q    <= pkt_done;
      frame_err_q <= err_d;
      // The watchdog only runs while a frame or packet is partially received.
      if (strobe_q || timeout)                     wd_q <= '0;
      else if (state_q != S_IDLE || idx_q != 2'd0) wd_q <= wd_q + WD_ONE;
      else                                         wd_q <= '0;
    end
  end

  assign rd_vld    = rd_vld_q;
  assign rd_data   = rd_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: directed packets plus randomized traffic checked against a packet-level model.
module tb_ps2_mouse_rx;

  localparam int FILT = 8;
  localparam int TMO  = 3000;
  localparam int LAT  = FILT + 4;
`ifdef PS2_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    logic [23:0] dat;
    int          at;
    int          tol;
  } ev_t;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_vld, frame_err;
  logic [23:0] rd_data;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_pkt = 0;
  int          n_err = 0;
  int          last_p = 0;
  logic [23:0] last_pkt = 24'h0;
  logic [23:0] prev_dat = 24'h0;
  ev_t         exp_q[$];
  logic [7:0]  pkt_buf[$];

  ps2_mouse_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  function automatic void push_ev(input bit is_err, input logic [23:0] d, input int at, input int tol);
    ev_t e;
    e.is_err = is_err;
    e.dat    = d;
    e.at     = at;
    e.tol    = tol;
    exp_q.push_back(e);
  endfunction

  // Packet-level reference: what one received byte does to the packet in progress.
  function automatic void model_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok, input int p);
    if (!stop_ok || (PCHK && !par_ok)) begin
      push_ev(1'b1, 24'h0, p + LAT, 0);
      pkt_buf.delete();
    end else if (pkt_buf.size() == 0 && !b[3]) begin
      push_ev(1'b1, 24'h0, p + LAT, 0);
    end else begin
      pkt_buf.push_back(b);
      if (pkt_buf.size() == 3) begin
        push_ev(1'b0, {pkt_buf[2], pkt_buf[1], pkt_buf[0]}, p + LAT, 0);
        pkt_buf.delete();
      end
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int hp, input bit glitch, input int abort_at);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == abort_at) return;
      ps2_data = fr[i];
      if (glitch && i > 0) begin
        tick(15);
        ps2_clk = 1'b0;
        tick(5);
        ps2_clk = 1'b1;
        tick(hp - 20);
      end else begin
        tick(hp);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        last_p = cyc;
        model_byte(b, !bad_par, !bad_stop, cyc);
      end
      tick(hp);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick($urandom_range(60, 150));
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int hp, input bit glitch);
    send_frame(b0, 1'b0, 1'b0, hp, glitch, 99);
    send_frame(b1, 1'b0, 1'b0, hp, glitch, 99);
    send_frame(b2, 1'b0, 1'b0, hp, glitch, 99);
  endtask

  task automatic stall();
    if (pkt_buf.size() != 0) push_ev(1'b1, 24'h0, last_p + LAT + TMO, 2);
    pkt_buf.delete();
    tick(TMO + 200);
  endtask

  always @(negedge clk_sys) begin
    ev_t e;
    if (!rst_n) begin
      chk("reset_rd_vld", 32'(rd_vld), 32'd0);
      chk("reset_frame_err", 32'(frame_err), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      prev_dat = 24'h0;
    end else begin
      if (rd_vld !== 1'b1) chk("rd_data_hold", 32'(rd_data), 32'(prev_dat));
      if (rd_vld === 1'b1 || frame_err === 1'b1) begin
        if (rd_vld === 1'b1) begin
          n_pkt++;
          last_pkt = rd_data;
        end
        if (frame_err === 1'b1) n_err++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({rd_vld, frame_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'({rd_vld, frame_err}), e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) chk("pkt_data", 32'(rd_data), 32'(e.dat));
          if (e.tol == 0) chk("event_cycle", 32'(cyc), 32'(e.at));
          else chk("event_cycle_window", 32'(cyc >= e.at - e.tol && cyc <= e.at + e.tol), 32'd1);
        end
      end
      prev_dat = rd_data;
    end
  end

  initial begin
    int p0, e0;
    logic [7:0] bb [3];
    int hp;
    bit gl;

    tick(5);
    chk("init_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick(20);

    p0 = n_pkt; e0 = n_err;
    send_pkt(8'h09, 8'h12, 8'hF0, 50, 1'b0);
    chk("good_pkt_data", 32'(last_pkt), 32'h00F01209);
    chk("good_pkt_count", 32'(n_pkt - p0), 32'd1);
    chk("good_pkt_errs", 32'(n_err - e0), 32'd0);

    p0 = n_pkt; e0 = n_err;
    send_frame(8'h08, 1'b0, 1'b0, 40, 1'b0, 99);
    send_frame(8'h33, 1'b1, 1'b0, 40, 1'b0, 99);
    if (!PCHK) send_frame(8'h44, 1'b0, 1'b0, 40, 1'b0, 99);
    send_pkt(8'h08, 8'h01, 8'h02, 40, 1'b0);
    chk("parity_pkt_data", 32'(last_pkt), 32'h00020108);
    chk("parity_errs", 32'(n_err - e0), PCHK ? 32'd1 : 32'd0);
    chk("parity_pkt_count", 32'(n_pkt - p0), PCHK ? 32'd1 : 32'd2);

    p0 = n_pkt; e0 = n_err;
    send_frame(8'h00, 1'b0, 1'b0, 40, 1'b0, 99);
    send_pkt(8'h18, 8'h05, 8'hFB, 40, 1'b0);
    chk("sync_pkt_data", 32'(last_pkt), 32'h00FB0518);
    chk("sync_errs", 32'(n_err - e0), 32'd1);

    p0 = n_pkt; e0 = n_err;
    send_pkt(8'h0B, 8'hFF, 8'h00, 40, 1'b1);
    chk("glitch_pkt_data", 32'(last_pkt), 32'h0000FF0B);
    chk("glitch_errs", 32'(n_err - e0), 32'd0);

    p0 = n_pkt; e0 = n_err;
    send_frame(8'h08, 1'b0, 1'b0, 40, 1'b0, 99);
    send_frame(8'h11, 1'b0, 1'b0, 40, 1'b0, 99);
    stall();
    chk("stall_errs", 32'(n_err - e0), 32'd1);
    send_pkt(8'h28, 8'h7F, 8'h80, 40, 1'b0);
    chk("stall_pkt_data", 32'(last_pkt), 32'h00807F28);
    chk("stall_pkt_count", 32'(n_pkt - p0), 32'd1);

    p0 = n_pkt; e0 = n_err;
    send_frame(8'h2C, 1'b0, 1'b0, 40, 1'b0, 6);
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    pkt_buf.delete();
    tick(4);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick(20);
    send_pkt(8'h2C, 8'h10, 8'hEF, 40, 1'b0);
    chk("postreset_pkt_data", 32'(last_pkt), 32'h00EF102C);
    chk("postreset_errs", 32'(n_err - e0), 32'd0);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) bb[j] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) bb[0][3] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        hp = $urandom_range(32, 45);
        gl = ($urandom_range(0, 9) < 3);
        send_frame(bb[j], $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, hp, gl, 99);
      end
    end
    stall();

    tick(50);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
